// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: widths, NOP encoding, reset vector,
// the IF/ID bundle and the per-edge fetch action.
package fetch_stage_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [ILEN-1:0] DEF_NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] INST_BYTES   = 32'd4;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_ADVANCE,
        ACT_REDIRECT,
        ACT_REJECT
    } fetch_act_e;

    // Sequential successor; carry out of bit 31 is dropped.
    function automatic logic [XLEN-1:0] pc_next(
        input logic [XLEN-1:0] pc
    );
        return pc + INST_BYTES;
    endfunction

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(
        input logic [XLEN-1:0] addr
    );
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Single-entry IF/ID pipeline register.
// Flush beats load; flush empties the slot and parks a NOP in it.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INST = DEF_NOP_INST
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_load,
    input  logic   i_flush,
    input  if_id_t i_data,
    output logic   o_valid,
    output if_id_t o_data
);

    logic   r_valid;
    if_id_t r_data;

    // Slot state: reset/flush empty it, load fills it, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid         <= 1'b0;
            r_data.inst     <= NOP_INST;
            r_data.pc       <= '0;
            r_data.pc_plus4 <= '0;
        end else if (i_flush) begin
            r_valid     <= 1'b0;
            r_data.inst <= NOP_INST;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem address, redirect/stall priority, IF/ID.
// Optional macro FETCH_MISALIGN_CHECK_EN rejects misaligned redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [ILEN-1:0] NOP_INST = DEF_NOP_INST
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [ILEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic            misalign_err
);

    logic [XLEN-1:0] r_pc;
    logic            w_advance;
    logic            w_redir_ok;
    logic            w_load;
    logic            w_flush;
    fetch_act_e      w_act;
    if_id_t          w_fetch;
    if_id_t          w_id;
    logic            w_id_valid;

    // Slot is free when empty or being drained by decode this cycle.
    assign w_advance = !w_id_valid || id_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_redir_ok = (redirect_pc[1:0] == 2'b00);
`else
    assign w_redir_ok = 1'b1;
`endif

    // Pick this edge's action: redirect, then advance, then hold.
    always_comb begin
        w_act = ACT_HOLD;
        unique case (1'b1)
            redirect_valid:
                w_act = w_redir_ok ? ACT_REDIRECT : ACT_REJECT;
            (!redirect_valid && w_advance):
                w_act = ACT_ADVANCE;
            default:
                w_act = ACT_HOLD;
        endcase
    end

    assign w_load  = (w_act == ACT_ADVANCE);
    assign w_flush = (w_act == ACT_REDIRECT) || (w_act == ACT_REJECT);

    // Program counter; a rejected redirect leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            unique case (w_act)
                ACT_REDIRECT: r_pc <= align_word(redirect_pc);
                ACT_ADVANCE:  r_pc <= pc_next(r_pc);
                default:      r_pc <= r_pc;
            endcase
        end
    end

    assign imem_addr = r_pc;

    assign w_fetch.inst     = imem_inst;
    assign w_fetch.pc       = r_pc;
    assign w_fetch.pc_plus4 = pc_next(r_pc);

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_data  (w_fetch),
        .o_valid (w_id_valid),
        .o_data  (w_id)
    );

    assign id_valid    = w_id_valid;
    assign id_inst     = w_id.inst;
    assign id_pc       = w_id.pc;
    assign id_pc_plus4 = w_id.pc_plus4;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign_err;

    // One-cycle pulse after a rejected redirect edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign_err <= 1'b0;
        end else begin
            r_misalign_err <= (w_act == ACT_REJECT);
        end
    end

    assign misalign_err = r_misalign_err;
`else
    // Low target bits are simply dropped when alignment is not checked.
    logic w_unused_lo;
    assign w_unused_lo  = ^redirect_pc[1:0];
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: random ready/redirect traffic
// against a transaction-level model of the fetch stream.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        misalign_err;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .misalign_err   (misalign_err)
    );

    // Instruction memory: a distinct word per aligned address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_inst = mem_f(imem_addr);

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] p4;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [31:0] pc_m;
    logic [31:0] held_m;
    bit          full_m;
    bit          err_m;
    bit          mon_en;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances at the edge.
    task automatic step(input bit rdy, input bit rv,
                        input logic [31:0] tgt);
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = tgt;
        if (full_m && rdy)
            sbq.push_back('{mem_f(held_m), held_m, held_m + 32'd4});
        @(posedge clk);
        err_m = 1'b0;
        if (rv) begin
            full_m = 1'b0;
            if (CHK && tgt[1:0] != 2'b00) err_m = 1'b1;
            else pc_m = tgt & ~32'h3;
        end else if (!full_m || rdy) begin
            held_m = pc_m;
            full_m = 1'b1;
            pc_m   = pc_m + 32'd4;
        end
        #1;
    endtask

    task automatic model_reset();
        pc_m   = RST_PC;
        full_m = 1'b0;
        err_m  = 1'b0;
        held_m = '0;
        sbq.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_id_valid"}, {31'b0, id_valid}, 32'd0);
        chk({tag, "_id_inst"}, id_inst, NOP);
        chk({tag, "_id_pc"}, id_pc, 32'd0);
        chk({tag, "_id_pc_plus4"}, id_pc_plus4, 32'd0);
        chk({tag, "_imem_addr"}, imem_addr, RST_PC);
        chk({tag, "_misalign"}, {31'b0, misalign_err}, 32'd0);
    endtask

    // Monitor: per-cycle state plus scoreboard pop on every transfer.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("id_valid", {31'b0, id_valid}, {31'b0, full_m});
            chk("imem_addr", imem_addr, pc_m);
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, err_m});
            if (!full_m) chk("bubble_inst", id_inst, NOP);
            if (id_valid && id_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got pc %h none expected",
                             id_pc);
                end else begin
                    e = sbq.pop_front();
                    chk("xfer_inst", id_inst, e.inst);
                    chk("xfer_pc", id_pc, e.pc);
                    chk("xfer_pc_plus4", id_pc_plus4, e.p4);
                end
            end
        end
    end

    logic [31:0] tgt;
    int          sel;

    initial begin
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mon_en         = 1'b0;
        model_reset();
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;

        // A,B then stall on B, resume
        step(1, 0, 0);
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        chk("stall_pc", id_pc, 32'd4);
        repeat (3) step(1, 0, 0);
        // redirect while draining
        step(1, 1, 32'h40);
        repeat (3) step(1, 0, 0);
        // redirect during stall
        step(0, 1, 32'h80);
        step(0, 0, 0);
        repeat (3) step(1, 0, 0);
        // wrap through the top of the address space
        step(1, 1, 32'hFFFF_FFF8);
        repeat (4) step(1, 0, 0);
        // misaligned target
        step(1, 1, 32'h42);
        repeat (3) step(1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 7);
            if (sel == 0)
                tgt = 32'hFFFF_FFF0 + {28'b0, 2'($urandom_range(0, 3)),
                                       2'b00};
            else if (sel == 1)
                tgt = $urandom;
            else
                tgt = $urandom & 32'h0000_0FFC;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 tgt);
        end

        // asynchronous reset mid-stream
        step(0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 1) != 0, $urandom_range(0, 15) == 0,
                 $urandom & 32'h0000_00FF);
        step(1, 0, 0);
        mon_en = 1'b0;
        chk("sb_drained", sbq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
